// File: rtl/dmem_write_buffer.sv
// Posted-write FIFO between the data cache and slow data memory; reads pass only after older
// writes drain. Optional read forwarding from queued entries: define WBUF_READ_FORWARD_EN.
module dmem_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cache_read,
  input  logic         cache_write,
  input  logic [27:0]  cache_addr,
  input  logic [127:0] cache_wdata,
  output logic [127:0] cache_rdata,
  output logic         cache_ready,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StRead
  } state_e;

  localparam logic [PTR_W:0] L_DEPTH = (PTR_W + 1)'(DEPTH);

  state_e             r_state;
  state_e             w_state_next;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [PTR_W:0]     r_count;
  logic [27:0]        r_addr [DEPTH];
  logic [127:0]       r_data [DEPTH];
  logic               r_cache_ready;
  logic [127:0]       r_cache_rdata;

  logic               w_push;
  logic               w_pop;
  logic               w_rd_done;
  logic               w_fwd;
  logic [127:0]       w_fwd_data;

  assign w_pop     = (r_state == StDrain) && mem_ready;
  assign w_rd_done = (r_state == StRead) && mem_ready;
  // A full queue still accepts when the head is popped in the same cycle.
  assign w_push    = cache_write && !r_cache_ready && (r_state != StRead) &&
                     ((r_count != L_DEPTH) || w_pop);

`ifdef WBUF_READ_FORWARD_EN
  logic             w_fwd_hit;
  logic [PTR_W-1:0] w_idx;

  // Scan oldest to youngest so the last match is the youngest entry.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (((PTR_W + 1)'(i) < r_count) && (r_addr[w_idx] == cache_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[w_idx];
      end
    end
  end

  assign w_fwd = cache_read && !cache_write && !r_cache_ready && (r_state != StRead) &&
                 w_fwd_hit;
`else
  assign w_fwd      = 1'b0;
  assign w_fwd_data = '0;
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (r_count != '0) begin
          w_state_next = StDrain;
        end else if (cache_read && !cache_write && !r_cache_ready) begin
          w_state_next = StRead;
        end
      end
      StDrain: if (mem_ready) w_state_next = StIdle;
      StRead:  if (mem_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Requests derive straight from state so reset drops them without waiting for a clock.
  always_comb begin
    mem_write = (r_state == StDrain);
    mem_read  = (r_state == StRead);
    mem_addr  = '0;
    mem_wdata = '0;
    if (r_state == StDrain) begin
      mem_addr  = r_addr[r_head];
      mem_wdata = r_data[r_head];
    end else if (r_state == StRead) begin
      mem_addr  = cache_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_cache_ready <= 1'b0;
      r_cache_rdata <= '0;
    end else begin
      r_state       <= w_state_next;
      r_cache_ready <= w_push || w_rd_done || w_fwd;
      r_count       <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_rd_done) begin
        r_cache_rdata <= mem_rdata;
      end else if (w_fwd) begin
        r_cache_rdata <= w_fwd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= cache_addr;
      r_data[r_tail] <= cache_wdata;
    end
  end

  assign cache_ready = r_cache_ready;
  assign cache_rdata = r_cache_rdata;

endmodule
